taylor_sweep_driver: RTL
========================

# taylor_sweep_driver

Initiator for the fixed-point Taylor cosine core. It generates a programmed sweep of angles, drives the core's `start`/`ready_out` handshake one point at a time, and stores each result in an internal result buffer. Results are read back through a registered read port. It sits between the configuration/host logic and the cosine core, so the core never needs host-side sequencing.

## Interface
- `W`, 24: angle/result width; unsigned Q1.23 fixed point.
- `DEPTH`, 16: result buffer entries; power of two.
- `AW`, 4: log2(`DEPTH`).
- `TIMEOUT_CYCLES`, 64: watchdog limit in clocks per point; used only with the macro described under Configuration.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  pulse high to start a sweep; ignored while `busy`.
- `cfg_start`  in  W  first angle; sampled on the accepted `go`.
- `cfg_step`  in  W  angle increment; sampled on the accepted `go`.
- `cfg_count`  in  AW+1  number of points; sampled on the accepted `go`.
- `busy`  out  1  high from the accepted `go` until `done`.
- `done`  out  1  one-cycle pulse when the sweep ends.
- `err`  out  1  sticky watchdog error; cleared on the next accepted `go`.
- `n_results`  out  AW+1  entries written in the current sweep.
- `core_start`  out  1  drives the core's `start`.
- `core_angle`  out  W  drives the core's `regAngle`.
- `core_ready`  in  1  from the core's `ready_out`.
- `core_result`  in  W  from the core's `tempAngle`.
- `rd_addr`  in  AW  result buffer read address.
- `rd_data`  out  W  buffer contents at `rd_addr`, registered.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE, FIN.
- IDLE, `go`=1: latch the config and set `core_angle`=`cfg_start`.
  - Points = min(`cfg_count`, `DEPTH`).
  - Clear `n_results` and `err`.
  - If points=0, go to FIN; otherwise go to ISSUE.
- ISSUE: `core_start`=1 for one cycle; then go to WAIT.
- WAIT: `core_start`=0; `core_angle` is held stable.
  - A result is accepted only on a rising edge of `core_ready` (`core_ready`=1 and registered `ready_q`=0). The level alone is never used, because `ready_out` is still high from the previous point during the core's S1/S2 states.
  - On a rising edge: write `core_result` to `buf[n_results]`, increment `n_results`, and go to RELEASE.
- RELEASE: `core_start`=1 for one cycle, which returns the core from S9 to S1. Then:
  - if `n_results`==points, go to FIN;
  - otherwise set `core_angle` += `cfg_step` and go to ISSUE.
- FIN: `done`=1 for one cycle; go to IDLE.
- Angle arithmetic wraps modulo 2^W with no saturation. Example: 0xFFFFF0 + 0x000020 = 0x000010.
- `ready_q` is updated every cycle in every state.
- Reset mid-sweep: return to IDLE; buffer contents are preserved and undefined after power-up. The core must be reset together with this block.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `err`=0, `n_results`=0.
  - `core_start`=0, `core_angle`=0.
  - `rd_data`=0, `ready_q`=0.
- `go` is accepted on the clock edge; `busy` is high on the next cycle.
- Per point with the cosine core: 10 clocks.
  - ISSUE: 1 clock.
  - WAIT: 8 clocks; the rising edge of `core_ready` appears 8 cycles after ISSUE.
  - RELEASE: 1 clock.
- Sweep of N points: `done` is asserted 1 + 10N + 1 cycles after `go`. Example: N=4 gives `done` at cycle 42.
- `rd_data` has 1-cycle read latency.
- A read and a write to the same address in the same cycle returns the old data.
- The buffer may be read at any time; entries at indices ≥ `n_results` are stale.
- `go` while `busy` is ignored; no queueing.

## Configuration
- `TAYLOR_SWEEP_TIMEOUT_EN` defined:
  - A counter starts at WAIT entry.
  - If no rising edge arrives after `TIMEOUT_CYCLES` clocks in WAIT: set `err`=1, write nothing, go to FIN, and end the sweep. `done` still pulses.
  - `n_results` reports the points completed before the timeout.
- Not defined: WAIT waits indefinitely; `err` is tied to 0.

## Test plan
- Basic sweep:
  - Stimulus: `cfg_start`=0, `cfg_step`=0x080000, `cfg_count`=4, with the real core attached.
  - Response: the angles 0x000000/0x080000/0x100000/0x180000 appear on `core_angle`; `done` arrives at cycle 42; `n_results`=4; `rd_addr`=0 gives 0x800000 (cos 0).
- Zero count: `cfg_count`=0 → `done` 2 cycles after `go`; `n_results`=0; `core_start` never asserted.
- Clamping: `cfg_count`=20 → exactly 16 ISSUE pulses; `n_results`=16; `done` at cycle 162.
- Angle wrap: `cfg_start`=0xFFFFF0, `cfg_step`=0x000020, `cfg_count`=2 → the second angle is 0x000010.
- Stale-ready guard and watchdog:
  - Stimulus: behavioural core holds `core_ready`=1 constantly, with `TAYLOR_SWEEP_TIMEOUT_EN` defined.
  - Response: no buffer write; `err`=1 after 64 WAIT cycles; `done` pulses; `n_results`=0.
- Reset mid-sweep and `go` while busy:
  - Reset asserted in WAIT of point 2 → all outputs at reset values on the next cycle; a fresh sweep then completes normally.
  - `go` asserted while `busy` → no effect.

Source files
------------

// File: rtl/taylor_sweep_driver.sv
// Sweep initiator for the Taylor cosine core: issues a programmed angle sweep and buffers results.
// Optional watchdog enabled by defining TAYLOR_SWEEP_TIMEOUT_EN.
module taylor_sweep_driver #(
    parameter int W              = 24,
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          go,
    input  logic [W-1:0]  cfg_start,
    input  logic [W-1:0]  cfg_step,
    input  logic [AW:0]   cfg_count,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   n_results,
    output logic          core_start,
    output logic [W-1:0]  core_angle,
    input  logic          core_ready,
    input  logic [W-1:0]  core_result,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE,
        FIN
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [W-1:0]  angle_q, angle_d;
    logic [W-1:0]  step_q, step_d;
    logic [AW:0]   points_q, points_d;
    logic [AW:0]   n_q, n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          start_q, start_d;
    logic          ready_q, ready_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          wr_en;
    logic          rise;

    logic [W-1:0]  result_mem [DEPTH];

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
`endif

    // ready_out stays high through the core's S1/S2, so only a fresh edge counts
    assign rise    = core_ready & ~ready_q;
    assign ready_d = core_ready;
    assign rd_data_d = result_mem[rd_addr];

    always_comb begin
        state_d  = state_q;
        angle_d  = angle_q;
        step_d   = step_q;
        points_d = points_q;
        n_d      = n_q;
        err_d    = err_q;
        wr_en    = 1'b0;
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
        wd_d     = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (go && !busy_q) begin
                    angle_d  = cfg_start;
                    step_d   = cfg_step;
                    points_d = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
                    n_d      = '0;
                    err_d    = 1'b0;
                    state_d  = (cfg_count == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (rise) begin
                    wr_en   = 1'b1;
                    n_d     = n_q + (AW+1)'(1);
                    state_d = RELEASE;
                end
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
                else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
`endif
            end
            RELEASE: begin
                if (n_q == points_q) begin
                    state_d = FIN;
                end else begin
                    angle_d = angle_q + step_q;
                    state_d = ISSUE;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        start_d = (state_d == ISSUE) || (state_d == RELEASE);
        // busy covers the done cycle, which follows FIN
        busy_d  = (state_d != IDLE) || (state_q == FIN);
        done_d  = (state_q == FIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            angle_q   <= '0;
            step_q    <= '0;
            points_q  <= '0;
            n_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            ready_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            angle_q   <= angle_d;
            step_q    <= step_d;
            points_q  <= points_d;
            n_q       <= n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // Buffer survives reset; contents are undefined only after power-up
    always_ff @(posedge clock) begin
        if (wr_en) begin
            result_mem[n_q[AW-1:0]] <= core_result;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign n_results  = n_q;
    assign core_start = start_q;
    assign core_angle = angle_q;
    assign rd_data    = rd_data_q;

endmodule
